// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
// Latency: n/a (constants, types and one helper only).
// Backpressure: n/a.
package aluSeqPkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // opSel encodings as presented by decode
   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   // One iteration per operand bit
   localparam int         ITER_COUNT = 32;
   localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 1);

   // ALU operand-2 mux select for "register operand"
   localparam logic [1:0] INPUT2_REG = 2'b00;

   typedef logic [1:0] op_t;

   // Operation captured on accept
   typedef struct packed {
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
   } op_req_t;

   // Both multiply flavours share the shift-add datapath
   function automatic logic is_mul(input op_t op);
      return !op[1];
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Decode-stage <-> sequencer bundle: op handshake, operands, pipeline control, result.
// Latency: n/a (wires only).
// Backpressure: startReady from the sequencer gates acceptance of startValid.
interface alu_sequencer_if;
   logic        startValid;
   logic        startReady;
   logic [1:0]  opSel;
   logic [31:0] operandA;
   logic [31:0] operandB;
   logic [1:0]  input2SelectIn;
   logic [1:0]  input2Select;
   logic        flush;
   logic        stallPipeline;
   logic        resultValid;
   logic [31:0] result;
   logic        busy;

   // Decode/pipeline side
   modport master (
      output startValid, opSel, operandA, operandB, input2SelectIn, flush,
      input  startReady, input2Select, stallPipeline, resultValid, result, busy
   );

   // Sequencer side
   modport slave (
      input  startValid, opSel, operandA, operandB, input2SelectIn, flush,
      output startReady, input2Select, stallPipeline, resultValid, result, busy
   );
endinterface

// File: rtl/alu_sequencer_mul_div_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the outputs.
module mulDivStep
   import aluSeqPkg::*;
(
   input  op_t         op,
   input  logic [31:0] operand_a,   // multiplicand
   input  logic [31:0] operand_b,   // divisor
   input  logic [63:0] acc_in,      // mul: {partial hi, multiplier}; div: {unused, dividend/quotient}
   input  logic [32:0] rem_in,      // div partial remainder
   output logic [63:0] acc_out,
   output logic [32:0] rem_out
);

   logic [32:0] add_sum;
   logic [33:0] rem_shift;
   logic [33:0] rem_diff;

   // Select between the multiply and divide recurrences
   always_comb begin
      // multiply: add multiplicand into the high half when the current multiplier bit is set
      add_sum   = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand_a} : 33'd0);
      // divide: bring the next dividend bit into the remainder; bit 33 of the diff is the borrow
      rem_shift = {rem_in, acc_in[31]};
      rem_diff  = rem_shift - {2'b00, operand_b};
      acc_out   = acc_in;
      rem_out   = rem_in;
      if (is_mul(op)) begin
         acc_out = {add_sum, acc_in[31:1]};
      end else if (rem_diff[33]) begin
         // divisor does not fit: restore, quotient bit 0
         rem_out = rem_shift[32:0];
         acc_out = {acc_in[63:32], acc_in[30:0], 1'b0};
      end else begin
         rem_out = rem_diff[32:0];
         acc_out = {acc_in[63:32], acc_in[30:0], 1'b1};
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer with IDLE/RUN/DONE FSM.
// Latency: resultValid in the 33rd cycle after the accept cycle; back-to-back accepts 34 cycles apart.
// Backpressure: startReady only in IDLE without flush; stallPipeline holds the front end while running.
module alu_sequencer
   import aluSeqPkg::*;
(
   input  logic           clk,
   input  logic           reset,
   alu_sequencer_if.slave bus
);

   logic [1:0]  state;
   logic [4:0]  iter;
   op_req_t     req;
   logic [63:0] acc;
   logic [32:0] rem;
   logic [63:0] acc_step;
   logic [32:0] rem_step;
   logic [31:0] result_q;
   logic [31:0] done_value;
   logic        accept;
   logic        done_ok;

   assign bus.startReady = (state == ST_IDLE) & !bus.flush;
   assign accept         = bus.startValid & bus.startReady;
   assign bus.busy       = (state != ST_IDLE);
   // reset is gated in so the front end is released immediately on async reset
   assign bus.stallPipeline = !reset & ((state == ST_RUN) |
                                        ((state == ST_IDLE) & bus.startValid & !bus.flush));
   assign bus.input2Select  = bus.busy ? INPUT2_REG : bus.input2SelectIn;

   // a flush in DONE swallows the result
   assign done_ok         = (state == ST_DONE) & !bus.flush;
   assign bus.resultValid = done_ok;
   assign bus.result      = done_ok ? done_value : result_q;

   mulDivStep u_step (
      .op        (req.op),
      .operand_a (req.a),
      .operand_b (req.b),
      .acc_in    (acc),
      .rem_in    (rem),
      .acc_out   (acc_step),
      .rem_out   (rem_step)
   );

   // Final value picked from the accumulator or remainder by operation
   always_comb begin
      done_value = acc[31:0];
      case (req.op)
         OP_MULHU: done_value = acc[63:32];
         OP_REMU:  done_value = rem[31:0];
         default:  done_value = acc[31:0];
      endcase
   end

   // FSM and iteration counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         iter  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_RUN;
                  iter  <= '0;
               end
            end
            ST_RUN: begin
               if (bus.flush) begin
                  state <= ST_IDLE;
               end else begin
                  iter <= iter + 5'd1;
                  if (iter == LAST_ITER) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Operand capture, per-cycle iteration and result retirement
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req      <= '0;
         acc      <= '0;
         rem      <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            req <= '{op: bus.opSel, a: bus.operandA, b: bus.operandB};
            // multiply starts with the multiplier in the low half, divide with the dividend
            acc <= is_mul(bus.opSel) ? {32'd0, bus.operandB} : {32'd0, bus.operandA};
            rem <= '0;
         end else if ((state == ST_RUN) && !bus.flush) begin
            acc <= acc_step;
            rem <= rem_step;
         end
         if (done_ok) begin
            result_q <= done_value;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: scoreboarded results, latency, stall, flush and reset behaviour.
// Latency: checks 33-cycle result latency and 34-cycle back-to-back spacing.
// Backpressure: checks startReady/stallPipeline/input2Select while busy.
module tb_alu_sequencer;
   import aluSeqPkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_result;

   op_t         tbl_op  [6] = '{OP_MULHU, OP_MUL, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
   logic [31:0] tbl_a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5};
   logic [31:0] tbl_b   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
   logic [31:0] tbl_exp [6] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};

   alu_sequencer_if bus_if ();

   alu_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      prod = {32'd0, a} * {32'd0, b};
      case (op)
         OP_MUL:   return prod[31:0];
         OP_MULHU: return prod[63:32];
         OP_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default:  return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Compare the output result against the oldest scoreboard entry
   task automatic pop_check(input string tag);
      logic [31:0] exp;
      exp = 'x;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      check({tag, "_result"}, bus_if.result, exp);
      last_result = exp;
   endtask

   // Called in the low phase of an IDLE cycle: present the op, it is accepted at the next edge
   task automatic accept_now(input op_t op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input string tag, input bit push);
      bus_if.startValid = 1'b1;
      bus_if.opSel      = op;
      bus_if.operandA   = a;
      bus_if.operandB   = b;
      #1;
      check({tag, "_ready"}, bus_if.startReady, 1'b1);
      check({tag, "_stall_acc"}, bus_if.stallPipeline, 1'b1);
      check({tag, "_in2_idle"}, bus_if.input2Select, bus_if.input2SelectIn);
      if (push) exp_q.push_back(exp);
   endtask

   // Follow an accepted op to its result pulse
   task automatic await_result(input string tag);
      int k;
      int stalls;
      int bad;
      bit seen;
      k = 0; stalls = 0; bad = 0; seen = 1'b0;
      @(posedge clk);
      #1 bus_if.startValid = 1'b0;
      while (!seen && k < 100) begin
         @(negedge clk);
         #1;
         k++;
         if (bus_if.resultValid === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (bus_if.stallPipeline === 1'b1) stalls++;
            if (bus_if.busy !== 1'b1 || bus_if.startReady !== 1'b0 ||
                bus_if.input2Select !== INPUT2_REG) bad++;
         end
      end
      check({tag, "_latency"}, k, 33);
      check({tag, "_run_stalls"}, stalls, 32);
      check({tag, "_busy_ctl"}, bad, 0);
      check({tag, "_stall_done"}, bus_if.stallPipeline, 1'b0);
      pop_check(tag);
   endtask

   initial begin
      int          accepts[$];
      int          bad;
      bit          change;
      op_t         op_var;
      logic [31:0] a_var;
      logic [31:0] b_var;

      reset = 1'b1;
      bus_if.startValid     = 1'b0;
      bus_if.opSel          = OP_MUL;
      bus_if.operandA       = '0;
      bus_if.operandB       = '0;
      bus_if.input2SelectIn = 2'b01;
      bus_if.flush          = 1'b0;
      last_result = '0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", bus_if.busy, 1'b0);
      check("rst_result", bus_if.result, 32'd0);
      check("rst_valid", bus_if.resultValid, 1'b0);
      check("rst_stall", bus_if.stallPipeline, 1'b0);
      @(posedge clk);
      #2 reset = 1'b0;

      // basic multiply with full latency/stall checks
      @(negedge clk);
      accept_now(OP_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, "mul_small", 1'b1);
      await_result("mul_small");

      // wide multiply and divide cases including divide by zero
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         accept_now(tbl_op[i], tbl_a[i], tbl_b[i], tbl_exp[i], $sformatf("op%0d", i), 1'b1);
         await_result($sformatf("op%0d", i));
      end
      @(negedge clk);
      #1;
      check("hold_idle", bus_if.result, last_result);

      // flush in RUN cycle 10
      accept_now(OP_MUL, 32'd3, 32'd5, 32'd15, "flush_op", 1'b0);
      @(posedge clk);
      #1 bus_if.startValid = 1'b0;
      repeat (10) @(negedge clk);
      #1 bus_if.flush = 1'b1;
      #1;
      check("flush_valid", bus_if.resultValid, 1'b0);
      check("flush_result", bus_if.result, last_result);
      @(posedge clk);
      #1 bus_if.flush = 1'b0;
      @(negedge clk);
      #1;
      check("flush_idle", bus_if.busy, 1'b0);
      check("flush_hold", bus_if.result, last_result);
      accept_now(OP_REMU, 32'd100, 32'd7, 32'd2, "post_flush", 1'b1);
      await_result("post_flush");

      // async reset mid-RUN with startValid held through release
      @(negedge clk);
      accept_now(OP_DIVU, 32'd1000, 32'd3, 32'd333, "rst_op", 1'b0);
      repeat (6) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_busy", bus_if.busy, 1'b0);
      check("midrst_stall", bus_if.stallPipeline, 1'b0);
      check("midrst_valid", bus_if.resultValid, 1'b0);
      check("midrst_result", bus_if.result, 32'd0);
      last_result = '0;
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      accept_now(OP_DIVU, 32'd1000, 32'd3, 32'd333, "post_rst", 1'b1);
      await_result("post_rst");

      // startValid held continuously: accepts every 34 cycles
      @(negedge clk);
      op_var = OP_MUL;
      a_var  = 32'd50;
      b_var  = 32'h9000_0001;
      bus_if.startValid     = 1'b1;
      bus_if.input2SelectIn = 2'b01;
      bus_if.opSel          = op_var;
      bus_if.operandA       = a_var;
      bus_if.operandB       = b_var;
      bad = 0;
      change = 1'b0;
      for (int c = 0; c < 102; c++) begin
         if (c > 0) @(negedge clk);
         if (change) begin
            op_var = op_t'(op_var + 2'd1);
            a_var  = a_var + 32'd11;
            bus_if.opSel    = op_var;
            bus_if.operandA = a_var;
            change = 1'b0;
         end
         #1;
         if (bus_if.startReady === 1'b1) begin
            accepts.push_back(c);
            exp_q.push_back(model(op_var, a_var, b_var));
            change = 1'b1;
         end
         if (bus_if.busy === 1'b1 &&
             (bus_if.startReady !== 1'b0 || bus_if.input2Select !== INPUT2_REG)) bad++;
         if (bus_if.busy === 1'b0 && bus_if.input2Select !== 2'b01) bad++;
         if (bus_if.resultValid === 1'b1) pop_check($sformatf("b2b_c%0d", c));
      end
      bus_if.startValid = 1'b0;
      check("b2b_count", accepts.size(), 3);
      check("b2b_gap1", (accepts.size() > 1) ? accepts[1] - accepts[0] : -1, 34);
      check("b2b_gap2", (accepts.size() > 2) ? accepts[2] - accepts[1] : -1, 34);
      check("b2b_busy_ctl", bad, 0);
      check("b2b_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have the port `clk  in  1`: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `reset  in  1`: asynchronous, active-high reset.
REQ-003 The block SHALL have the port `startValid  in  1`: the decode stage presents a multi-cycle op.
REQ-004 The block SHALL have the port `startReady  out  1`: the sequencer accepts the op this cycle.
REQ-005 The block SHALL have the port `opSel  in  2`, encoded 00 MUL (low 32), 01 MULHU (high 32, unsigned), 10 DIVU, 11 REMU.
REQ-006 The block SHALL have the port `operandA  in  32`: rs1 value, sampled on accept.
REQ-007 The block SHALL have the port `operandB  in  32`: rs2 value, sampled on accept.
REQ-008 The block SHALL have the port `input2SelectIn  in  2`: the ALU operand-2 select from decode.
REQ-009 The block SHALL have the port `input2Select  out  2`: the select driven to the ALU operand-2 mux.
REQ-010 The block SHALL have the port `flush  in  1`: a branch/exception flush that aborts any op.
REQ-011 The block SHALL have the port `stallPipeline  out  1`: holds the IF/ID/EX stages.
REQ-012 The block SHALL have the port `resultValid  out  1`: a one-cycle pulse marking `result` as valid.
REQ-013 The block SHALL have the port `result  out  32`: the op result.
REQ-014 The block SHALL have the port `busy  out  1`: high whenever state != IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and DONE.
REQ-016 `startReady` SHALL equal (state==IDLE) & !flush.
REQ-017 On accept (startValid & startReady), the block SHALL latch operandA, operandB and opSel, clear the 5-bit iteration counter and go IDLE->RUN.
REQ-018 In RUN, the block SHALL perform one shift-add (MUL/MULHU) or restoring shift-subtract (DIVU/REMU) step per cycle and increment the counter.
REQ-019 The counter SHALL run 0..31; when it equals 31 the block SHALL go RUN->DONE (32 RUN cycles total).
REQ-020 In DONE, the block SHALL drive `resultValid`=1 for exactly one cycle, then return to IDLE; the first resultValid SHALL occur 33 cycles after the accept edge.
REQ-021 `result` SHALL hold its last value outside DONE and SHALL be 0 after reset.
REQ-022 Arithmetic rules: the product SHALL use a 64-bit accumulator; MUL returns [31:0] and MULHU returns [63:32]; the divider SHALL use a 33-bit partial remainder; all operations SHALL be unsigned.
REQ-023 Divide by zero SHALL yield DIVU=0xFFFFFFFF and REMU=operandA, with no trap and the same latency.
REQ-024 `stallPipeline` SHALL equal (state==RUN) | (state==IDLE & startValid & !flush); it SHALL be low in DONE so the result retires.
REQ-025 `input2Select` SHALL be 2'b00 (register operand) while busy, and `input2SelectIn` otherwise.
REQ-026 If `flush` is asserted in RUN or DONE, the next state SHALL be IDLE, with no resultValid and `result` unchanged.
REQ-027 If `flush` and `startValid` are asserted together in IDLE, the op SHALL NOT be accepted.
REQ-028 The block SHALL ignore `startValid` while busy.
REQ-029 After DONE, the block SHALL return to IDLE; an op presented on that IDLE cycle SHALL be accepted, giving back-to-back ops a 34-cycle spacing.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, counter=0, accumulators=0, result=0, resultValid=0, stallPipeline=0 and busy=0.
REQ-031 Reset mid-RUN SHALL discard the op, with no resultValid after release.
REQ-032 The first accept SHALL be possible on the first clock edge after reset deasserts.

Structure
REQ-033 A shared package aluSeqPkg SHALL hold the state encoding, the opSel encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU), ITER_COUNT=32 and INPUT2_REG=2'b00.
REQ-034 The block SHALL have one sub-module, mulDivStep, which is combinational: one multiply or divide iteration (accumulator/remainder in, next value out).
REQ-035 alu_sequencer SHALL own the FSM, the counter, the operand registers and the handshake.

Verification
REQ-036 The bench SHALL cover: MUL A=0x0000_1234, B=0x0000_0010 -> resultValid exactly 33 cycles after accept, result=0x0001_2340; stallPipeline high over the accept cycle plus the 32 RUN cycles.
REQ-037 The bench SHALL cover: MULHU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> result=0xFFFF_FFFE; MUL with the same operands -> result=0x0000_0001.
REQ-038 The bench SHALL cover: DIVU A=100, B=7 -> 14; REMU A=100, B=7 -> 2; DIVU A=5, B=0 -> 0xFFFF_FFFF; REMU A=5, B=0 -> 5.
REQ-039 The bench SHALL cover: flush at RUN cycle 10 -> IDLE next cycle, no resultValid, result unchanged, and a new op accepted the cycle after.
REQ-040 The bench SHALL cover: reset asserted asynchronously mid-RUN -> outputs zero immediately; startValid held high through reset release -> accept on the first post-reset edge.
REQ-041 The bench SHALL cover: startValid held continuously -> accepts spaced 34 cycles apart, startReady low while busy, and input2Select forced to 00 while busy with input2SelectIn=01.
